// File: rtl/cmd_mem_pkg.sv
// Shared definitions for the 256-entry command register memory and its scheduler.
package cmd_mem_pkg;

  localparam int unsigned DW     = 338;
  localparam int unsigned AW     = 8;
  localparam int unsigned N_IDX  = 255;
  localparam int unsigned RD_LAT = 2;
  localparam logic [63:0] LATE_TH    = 64'd1000;
  localparam logic [63:0] EMPTY_TIME = 64'hFFFF_FFFF_FFFF_FFFF;

  // Field bit positions within a memory word
  localparam int unsigned TS_MSB    = 337, TS_LSB    = 274;
  localparam int unsigned FREQ_MSB  = 273, FREQ_LSB  = 226;
  localparam int unsigned FSTEP_MSB = 225, FSTEP_LSB = 178;
  localparam int unsigned FRATE_MSB = 177, FRATE_LSB = 146;
  localparam int unsigned NIMP_MSB  = 145, NIMP_LSB  = 130;
  localparam int unsigned TYPE_MSB  = 129, TYPE_LSB  = 128;
  localparam int unsigned TI_MSB    = 127, TI_LSB    = 96;
  localparam int unsigned TP_MSB    = 95,  TP_LSB    = 64;
  localparam int unsigned TB1_MSB   = 63,  TB1_LSB   = 32;
  localparam int unsigned TB2_MSB   = 31,  TB2_LSB   = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_CHECK, S_ISSUE, S_CLEAR, S_NEXT, S_YIELD
  } sched_state_e;

  typedef struct packed {
    logic [63:0] time_start;
    logic [47:0] freq;
    logic [47:0] freq_step;
    logic [31:0] freq_rate;
    logic [15:0] n_impulse;
    logic [1:0]  cmd_type;
    logic [31:0] ti;
    logic [31:0] tp;
    logic [31:0] tblank1;
    logic [31:0] tblank2;
  } cmd_word_t;

endpackage

// File: rtl/sched_rd_arb.sv
// Read-port ownership: scheduler reads unless the writer's search holds the grant.
module sched_rd_arb
  import cmd_mem_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sched_rd_c,
  input  logic [AW-1:0] sched_addr_c,
  input  logic          srch_gnt_c,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  output logic          srch_gnt
);

  logic          rd_en_q, rd_en_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          srch_gnt_q, srch_gnt_d;

  always_comb begin
    rd_en_d    = sched_rd_c && !srch_gnt_c;
    rd_addr_d  = rd_en_d ? sched_addr_c : '0;
    srch_gnt_d = srch_gnt_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      srch_gnt_q <= 1'b0;
    end else begin
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      srch_gnt_q <= srch_gnt_d;
    end
  end

  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign srch_gnt = srch_gnt_q;

endmodule

// File: rtl/cmd_time_scheduler.sv
// Sweeps the command memory, issues entries whose start time has arrived, then
// asks the writer to erase them. Yields the read port to the writer between entries.
module cmd_time_scheduler
  import cmd_mem_pkg::*;
(
  input  logic          CLK,
  input  logic          rst_n,
  input  logic          EN,
  input  logic [63:0]   SYS_TIME,
  output logic [AW-1:0] RD_ADDR,
  output logic          RD_EN,
  input  logic [DW-1:0] RD_Q,
  input  logic          SRCH_REQ,
  output logic          SRCH_GNT,
  output logic          CLR_REQ,
  output logic [AW-1:0] CLR_ADDR,
  input  logic          CLR_ACK,
  output logic          CMD_VALID,
  input  logic          CMD_READY,
  output logic [DW-1:0] CMD_DATA,
  output logic [AW-1:0] CMD_ADDR,
  output logic          CMD_LATE,
  output logic          SWEEP_DONE,
  output logic [15:0]   ISSUE_CNT
);

  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

  sched_state_e  state_q, state_d;
  logic [AW-1:0] scan_q, scan_d;
  logic [1:0]    wcnt_q, wcnt_d;
  cmd_word_t     hold_q, hold_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic [DW-1:0] cmd_data_q, cmd_data_d;
  logic [AW-1:0] cmd_addr_q, cmd_addr_d;
  logic          cmd_late_q, cmd_late_d;
  logic          clr_req_q, clr_req_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          sweep_done_q, sweep_done_d;
  logic [15:0]   issue_cnt_q, issue_cnt_d;
  logic [63:0]   age_c;
  logic          rd_req_c, yield_c;

  assign age_c = SYS_TIME - hold_q.time_start;

  always_comb begin
    state_d      = state_q;
    scan_d       = scan_q;
    wcnt_d       = wcnt_q;
    hold_d       = hold_q;
    cmd_data_d   = cmd_data_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_late_d   = cmd_late_q;
    issue_cnt_d  = issue_cnt_q;
    sweep_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (SRCH_REQ)  state_d = S_YIELD;
        else if (EN)   state_d = S_READ;
      end
      S_READ: begin
        wcnt_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (wcnt_q == WAIT_LAST) begin
          hold_d  = cmd_word_t'(RD_Q);
          state_d = S_CHECK;
        end else begin
          wcnt_d = wcnt_q + 2'd1;
        end
      end
      S_CHECK: begin
        if (hold_q.time_start == EMPTY_TIME || hold_q.time_start > SYS_TIME) begin
          state_d = S_NEXT;
        end else begin
          cmd_data_d = hold_q;
          cmd_addr_d = scan_q;
          cmd_late_d = age_c > LATE_TH;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (CMD_READY) begin
          issue_cnt_d = issue_cnt_q + 16'd1;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        if (CLR_ACK) state_d = S_NEXT;
      end
      S_NEXT: begin
        // Entry boundary: the only place besides IDLE where the writer can be granted
        sweep_done_d = scan_q == AW'(N_IDX);
        scan_d       = sweep_done_d ? '0 : scan_q + AW'(1);
        if (SRCH_REQ)  state_d = S_YIELD;
        else if (EN)   state_d = S_READ;
        else           state_d = S_IDLE;
      end
      S_YIELD: begin
        if (!SRCH_REQ) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cmd_valid_d = state_d == S_ISSUE;
    clr_req_d   = state_d == S_CLEAR;
    clr_addr_d  = clr_req_d ? scan_q : '0;
  end

  assign rd_req_c = state_d == S_READ;
  assign yield_c  = state_d == S_YIELD;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      scan_q       <= '0;
      wcnt_q       <= '0;
      hold_q       <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_data_q   <= '0;
      cmd_addr_q   <= '0;
      cmd_late_q   <= 1'b0;
      clr_req_q    <= 1'b0;
      clr_addr_q   <= '0;
      sweep_done_q <= 1'b0;
      issue_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      scan_q       <= scan_d;
      wcnt_q       <= wcnt_d;
      hold_q       <= hold_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_data_q   <= cmd_data_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_late_q   <= cmd_late_d;
      clr_req_q    <= clr_req_d;
      clr_addr_q   <= clr_addr_d;
      sweep_done_q <= sweep_done_d;
      issue_cnt_q  <= issue_cnt_d;
    end
  end

  sched_rd_arb u_rd_arb (
    .clk          (CLK),
    .rst_n        (rst_n),
    .sched_rd_c   (rd_req_c),
    .sched_addr_c (scan_d),
    .srch_gnt_c   (yield_c),
    .rd_en        (RD_EN),
    .rd_addr      (RD_ADDR),
    .srch_gnt     (SRCH_GNT)
  );

  assign CMD_VALID  = cmd_valid_q;
  assign CMD_DATA   = cmd_data_q;
  assign CMD_ADDR   = cmd_addr_q;
  assign CMD_LATE   = cmd_late_q;
  assign CLR_REQ    = clr_req_q;
  assign CLR_ADDR   = clr_addr_q;
  assign SWEEP_DONE = sweep_done_q;
  assign ISSUE_CNT  = issue_cnt_q;

endmodule

// File: doc/cmd_time_scheduler.md
Name: cmd_time_scheduler

Overview:
- Sequencer for the 256-entry command register memory (338-bit words) that the command writer fills.
- Sweeps the memory continuously through its read port and compares each entry's TIME_START against system time.
- Hands each due command to the synthesizer control path through a valid/ready handshake, then asks the writer to erase that entry.
- Arbitrates the memory read port between itself and the writer's free-slot search.

Parameters:
N_IDX, 255, last memory address; the sweep covers addresses 0..N_IDX.
AW, 8, memory address width.
DW, 338, memory word width.
RD_LAT, 2, cycles from rden/address to valid q.
LATE_TH, 64'd1000, late threshold in system-time ticks.

Ports:
CLK  in  1  system clock
rst_n  in  1  asynchronous active-low reset
EN  in  1  scheduler enable
SYS_TIME  in  64  free-running system time, unsigned
RD_ADDR  out  AW  memory read address
RD_EN  out  1  memory read enable
RD_Q  in  DW  memory read data
SRCH_REQ  in  1  writer requests the read port
SRCH_GNT  out  1  read port granted to the writer
CLR_REQ  out  1  request writer to erase CLR_ADDR
CLR_ADDR  out  AW  address to erase
CLR_ACK  in  1  one-cycle pulse: erase accepted
CMD_VALID  out  1  command word valid
CMD_READY  in  1  downstream accepts command
CMD_DATA  out  DW  issued command word
CMD_ADDR  out  AW  memory address of the issued command
CMD_LATE  out  1  issued command was late
SWEEP_DONE  out  1  one-cycle pulse at wrap from N_IDX to 0
ISSUE_CNT  out  16  commands issued, wraps at 0xFFFF

Behaviour:
- Reset: all outputs 0; state IDLE; scan address 0; ISSUE_CNT 0.
- Word layout, MSB first:
  - TIME_START[337:274], FREQ[273:226], FREQ_STEP[225:178], FREQ_RATE[177:146]
  - N_impulse[145:130], TYPE[129:128], Ti[127:96], Tp[95:64], Tblank1[63:32], Tblank2[31:0]
- Empty entry: TIME_START == 64'hFFFF_FFFF_FFFF_FFFF.
- States:
  - IDLE: if SRCH_REQ, go YIELD; else if EN, go READ.
  - READ: RD_EN=1, RD_ADDR=scan address, for one cycle; then WAIT.
  - WAIT: count RD_LAT-1 further cycles; capture RD_Q into a holding register; go CHECK.
  - CHECK:
    - empty entry, or TIME_START > SYS_TIME (unsigned): go NEXT.
    - otherwise: go ISSUE; set CMD_LATE = (SYS_TIME - TIME_START > LATE_TH), computed with a 64-bit unsigned subtract.
  - ISSUE: CMD_VALID=1, CMD_DATA = holding register, CMD_ADDR = scan address.
    - CMD_DATA/CMD_ADDR/CMD_LATE stay stable until CMD_READY.
    - Transfer occurs in the cycle CMD_VALID && CMD_READY.
    - On transfer: ISSUE_CNT+1; CMD_VALID drops next cycle; go CLEAR.
  - CLEAR: CLR_REQ=1, CLR_ADDR = scan address, held until CLR_ACK; then go NEXT.
  - NEXT:
    - scan address +1; at N_IDX it wraps to 0 and pulses SWEEP_DONE.
    - then: if SRCH_REQ, go YIELD; else if EN, go READ; else go IDLE.
  - YIELD: SRCH_GNT=1, scheduler does not drive RD_EN (0); return to IDLE when SRCH_REQ falls. The scan address is preserved.
- Arbitration: the grant is given only at entry boundaries (IDLE/NEXT), never mid-read or mid-issue. Writer worst-case wait is bounded by RD_LAT+2 cycles plus downstream handshake stalls.
- EN falling mid-entry: the current entry completes (including ISSUE/CLEAR); then IDLE.
- CLR_ACK outside CLEAR is ignored. CMD_READY outside ISSUE is ignored.
- SRCH_REQ rising during ISSUE/CLEAR: served at the next NEXT.
- Reset mid-operation: immediate return to reset values. A half-issued command is not retried; the entry remains in memory and is found again on the next sweep.
- Simultaneous SRCH_REQ and EN in IDLE: SRCH_REQ wins.

Decomposition:
- Package cmd_mem_pkg:
  - DW, AW, N_IDX
  - field bit-position constants
  - EMPTY_TIME constant
  - sched state enum typedef
  - packed struct for the command word (shared with the writer)
- One sub-module: sched_rd_arb, the read-port mux/grant logic between scheduler and writer search.

Test Plan:
1. Reset, EN=1, all entries empty -> no CMD_VALID; SWEEP_DONE pulses every 256×(RD_LAT+3) cycles; RD_ADDR sequence 0..255,0.
2. Entry 5 TIME_START=100, SYS_TIME=150, CMD_READY=1, CLR_ACK one cycle after CLR_REQ -> CMD_VALID with CMD_ADDR=5, CMD_LATE=0; CLR_REQ with CLR_ADDR=5; ISSUE_CNT=1.
3. Entry 7 TIME_START=10, SYS_TIME=2000 -> CMD_LATE=1. Entry 8 TIME_START=3000, SYS_TIME=2000 -> not issued.
4. CMD_READY held 0 for 20 cycles in ISSUE -> CMD_DATA/CMD_ADDR stable and CLR_REQ stays 0; transfer occurs on the cycle CMD_READY=1.
5. SRCH_REQ asserted during CLEAR -> SRCH_GNT asserted only after NEXT; RD_EN=0 while granted; scan resumes at the next address after SRCH_REQ falls.
6. rst_n pulsed low during ISSUE -> all outputs 0 asynchronously; after release the same entry is re-issued on the next sweep.
